// File: rtl/mmu_bus_arbiter.sv
// mmu_bus_arbiter: shares one AXI4-Lite master port between fetch reads and mem reads/writes.
// Define MMU_ARB_ROUND_ROBIN_EN for round-robin I/D arbitration; default is fixed D-over-I priority.
module mmu_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   i_araddr,
    input  logic [2:0]          i_arprot,
    input  logic                i_arvalid,
    output logic                i_arready,
    output logic [DATA_W-1:0]   i_rdata,
    output logic [1:0]          i_rresp,
    output logic                i_rvalid,
    input  logic                i_rready,
    input  logic [ADDR_W-1:0]   d_araddr,
    input  logic [2:0]          d_arprot,
    input  logic                d_arvalid,
    output logic                d_arready,
    output logic [DATA_W-1:0]   d_rdata,
    output logic [1:0]          d_rresp,
    output logic                d_rvalid,
    input  logic                d_rready,
    input  logic [ADDR_W-1:0]   d_awaddr,
    input  logic [2:0]          d_awprot,
    input  logic                d_awvalid,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    input  logic                d_wvalid,
    output logic                d_awready,
    output logic                d_wready,
    output logic [1:0]          d_bresp,
    output logic                d_bvalid,
    input  logic                d_bready,
    output logic [ADDR_W-1:0]   axi_araddr,
    output logic [2:0]          axi_arprot,
    output logic                axi_arvalid,
    input  logic                axi_arready,
    input  logic [DATA_W-1:0]   axi_rdata,
    input  logic [1:0]          axi_rresp,
    input  logic                axi_rvalid,
    output logic                axi_rready,
    output logic [ADDR_W-1:0]   axi_awaddr,
    output logic [2:0]          axi_awprot,
    output logic                axi_awvalid,
    input  logic                axi_awready,
    output logic [DATA_W-1:0]   axi_wdata,
    output logic [DATA_W/8-1:0] axi_wstrb,
    output logic                axi_wvalid,
    input  logic                axi_wready,
    input  logic [1:0]          axi_bresp,
    input  logic                axi_bvalid,
    output logic                axi_bready
);
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;

    state_t r_state;
    logic   r_grant_d;
    logic   r_last_d;
    logic   w_idle;
    logic   w_d_wr;
    logic   w_d_req;
    logic   w_pick_d;
    logic   w_any;
    logic   w_aw_done;
    logic   w_w_done;

    assign w_idle  = r_state == IDLE;
    assign w_d_wr  = d_awvalid && d_wvalid;
    assign w_d_req = w_d_wr || d_arvalid;
    assign w_any   = w_d_req || i_arvalid;
`ifdef MMU_ARB_ROUND_ROBIN_EN
    assign w_pick_d = w_d_req && (!i_arvalid || !r_last_d);
`else
    assign w_pick_d = w_d_req;
`endif

    assign i_arready = w_idle && i_arvalid && !w_pick_d;
    assign d_arready = w_idle && w_pick_d && !w_d_wr;
    assign d_awready = w_idle && w_pick_d && w_d_wr;
    assign d_wready  = d_awready;

    // Response data passes straight through; only the valids are steered.
    assign i_rdata    = axi_rdata;
    assign i_rresp    = axi_rresp;
    assign d_rdata    = axi_rdata;
    assign d_rresp    = axi_rresp;
    assign i_rvalid   = r_state == RD_DATA && !r_grant_d && axi_rvalid;
    assign d_rvalid   = r_state == RD_DATA && r_grant_d && axi_rvalid;
    assign axi_rready = r_state == RD_DATA && (r_grant_d ? d_rready : i_rready);
    assign d_bresp    = axi_bresp;
    assign d_bvalid   = r_state == WR_RESP && axi_bvalid;
    assign axi_bready = r_state == WR_RESP && d_bready;

    assign w_aw_done = !axi_awvalid || axi_awready;
    assign w_w_done  = !axi_wvalid || axi_wready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_grant_d   <= 1'b1;
            r_last_d    <= 1'b1;
            axi_araddr  <= '0;
            axi_arprot  <= '0;
            axi_arvalid <= 1'b0;
            axi_awaddr  <= '0;
            axi_awprot  <= '0;
            axi_awvalid <= 1'b0;
            axi_wdata   <= '0;
            axi_wstrb   <= '0;
            axi_wvalid  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_last_d  <= w_any ? w_pick_d : r_last_d;
                    r_grant_d <= w_any ? w_pick_d : r_grant_d;
                    if (w_pick_d && w_d_wr) begin
                        axi_awaddr  <= d_awaddr;
                        axi_awprot  <= d_awprot;
                        axi_wdata   <= d_wdata;
                        axi_wstrb   <= d_wstrb;
                        axi_awvalid <= 1'b1;
                        axi_wvalid  <= 1'b1;
                        r_state     <= WR_REQ;
                    end else if (w_any) begin
                        axi_araddr  <= w_pick_d ? d_araddr : i_araddr;
                        axi_arprot  <= w_pick_d ? d_arprot : i_arprot;
                        axi_arvalid <= 1'b1;
                        r_state     <= RD_ADDR;
                    end
                end
                RD_ADDR: begin
                    if (axi_arready) begin
                        axi_arvalid <= 1'b0;
                        r_state     <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (axi_rvalid && axi_rready)
                        r_state <= IDLE;
                end
                WR_REQ: begin
                    if (axi_awready)
                        axi_awvalid <= 1'b0;
                    if (axi_wready)
                        axi_wvalid <= 1'b0;
                    if (w_aw_done && w_w_done)
                        r_state <= WR_RESP;
                end
                WR_RESP: begin
                    if (axi_bvalid && d_bready)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mmu_bus_arbiter.sv
// tb_mmu_bus_arbiter: directed-vector bench for mmu_bus_arbiter.
// Inputs change on negedge; outputs are checked away from the rising edge.
module tb_mmu_bus_arbiter;
    logic        clk = 0;
    logic        rst = 1;
    logic [31:0] i_araddr = 0;
    logic [2:0]  i_arprot = 0;
    logic        i_arvalid = 0;
    logic        i_arready;
    logic [31:0] i_rdata;
    logic [1:0]  i_rresp;
    logic        i_rvalid;
    logic        i_rready = 0;
    logic [31:0] d_araddr = 0;
    logic [2:0]  d_arprot = 0;
    logic        d_arvalid = 0;
    logic        d_arready;
    logic [31:0] d_rdata;
    logic [1:0]  d_rresp;
    logic        d_rvalid;
    logic        d_rready = 0;
    logic [31:0] d_awaddr = 0;
    logic [2:0]  d_awprot = 0;
    logic        d_awvalid = 0;
    logic [31:0] d_wdata = 0;
    logic [3:0]  d_wstrb = 0;
    logic        d_wvalid = 0;
    logic        d_awready;
    logic        d_wready;
    logic [1:0]  d_bresp;
    logic        d_bvalid;
    logic        d_bready = 0;
    logic [31:0] axi_araddr;
    logic [2:0]  axi_arprot;
    logic        axi_arvalid;
    logic        axi_arready = 0;
    logic [31:0] axi_rdata = 0;
    logic [1:0]  axi_rresp = 0;
    logic        axi_rvalid = 0;
    logic        axi_rready;
    logic [31:0] axi_awaddr;
    logic [2:0]  axi_awprot;
    logic        axi_awvalid;
    logic        axi_awready = 0;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wvalid;
    logic        axi_wready = 0;
    logic [1:0]  axi_bresp = 0;
    logic        axi_bvalid = 0;
    logic        axi_bready;

    int n_chk = 0;
    int n_bad = 0;
    logic exp_d;

    always #5 clk = ~clk;

    mmu_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .i_araddr(i_araddr), .i_arprot(i_arprot), .i_arvalid(i_arvalid), .i_arready(i_arready),
        .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rvalid(i_rvalid), .i_rready(i_rready),
        .d_araddr(d_araddr), .d_arprot(d_arprot), .d_arvalid(d_arvalid), .d_arready(d_arready),
        .d_rdata(d_rdata), .d_rresp(d_rresp), .d_rvalid(d_rvalid), .d_rready(d_rready),
        .d_awaddr(d_awaddr), .d_awprot(d_awprot), .d_awvalid(d_awvalid),
        .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_wvalid(d_wvalid),
        .d_awready(d_awready), .d_wready(d_wready),
        .d_bresp(d_bresp), .d_bvalid(d_bvalid), .d_bready(d_bready),
        .axi_araddr(axi_araddr), .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_arvalid", axi_arvalid, 0);
        chk("rst_awvalid", axi_awvalid, 0);
        chk("rst_wvalid", axi_wvalid, 0);
        chk("rst_rready", axi_rready, 0);
        chk("rst_bready", axi_bready, 0);
        chk("rst_araddr", axi_araddr, 0);
        chk("rst_awaddr", axi_awaddr, 0);
        chk("rst_wdata", axi_wdata, 0);
        chk("rst_wstrb", axi_wstrb, 0);
        chk("rst_prot", {axi_arprot, axi_awprot}, 0);
        chk("rst_accept", {i_arready, d_arready, d_awready, d_wready}, 0);
        chk("rst_rsp_valid", {i_rvalid, d_rvalid, d_bvalid}, 0);
        rst = 0;

        // single fetch read, arready two cycles after the address goes out
        @(negedge clk);
        i_araddr = 32'h100; i_arprot = 3'b101; i_arvalid = 1; i_rready = 1; d_rready = 1;
        #1 chk("t1_i_arready", i_arready, 1);
        chk("t1_d_arready", d_arready, 0);
        @(negedge clk);
        i_arvalid = 0;
        chk("t1_arvalid", axi_arvalid, 1);
        chk("t1_araddr", axi_araddr, 32'h100);
        chk("t1_arprot", axi_arprot, 3'b101);
        chk("t1_rready_addr", axi_rready, 0);
        #1 chk("t1_i_arready_low", i_arready, 0);
        @(negedge clk);
        axi_arready = 1;
        chk("t1_arvalid_hold", axi_arvalid, 1);
        @(negedge clk);
        axi_arready = 0; axi_rvalid = 1; axi_rdata = 32'hDEADBEEF; axi_rresp = 0;
        #1 chk("t1_arvalid_clr", axi_arvalid, 0);
        chk("t1_i_rvalid", i_rvalid, 1);
        chk("t1_i_rdata", i_rdata, 32'hDEADBEEF);
        chk("t1_i_rresp", i_rresp, 0);
        chk("t1_d_rvalid", d_rvalid, 0);
        chk("t1_axi_rready", axi_rready, 1);
        @(negedge clk);
        axi_rvalid = 0;
        #1 chk("t1_idle_rvalid", i_rvalid, 0);
        chk("t1_idle_rready", axi_rready, 0);

        // simultaneous I and D reads held for four transactions (last=I here)
        i_araddr = 32'h300; d_araddr = 32'h400;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            axi_rvalid = 0; i_arvalid = 1; d_arvalid = 1;
`ifdef MMU_ARB_ROUND_ROBIN_EN
            exp_d = (k % 2) == 0;
`else
            exp_d = 1;
`endif
            #1 chk("t3_d_grant", d_arready, exp_d);
            chk("t3_i_grant", i_arready, !exp_d);
            @(negedge clk);
            chk("t3_araddr", axi_araddr, exp_d ? 32'h400 : 32'h300);
            axi_arready = 1;
            @(negedge clk);
            axi_arready = 0; axi_rvalid = 1; axi_rdata = k;
            #1 chk("t3_d_rvalid", d_rvalid, exp_d);
            chk("t3_i_rvalid", i_rvalid, !exp_d);
        end
        @(negedge clk);
        axi_rvalid = 0; i_arvalid = 0; d_arvalid = 0;

        // mem write, awready one cycle before wready, SLVERR response
        @(negedge clk);
        d_awaddr = 32'h2000; d_awprot = 3'b010; d_wdata = 32'h12345678; d_wstrb = 4'hF;
        d_awvalid = 1; d_wvalid = 1; d_bready = 1;
        #1 chk("t2_accept", {d_awready, d_wready, d_arready, i_arready}, 4'b1100);
        @(negedge clk);
        d_awvalid = 0; d_wvalid = 0;
        chk("t2_valids", {axi_awvalid, axi_wvalid}, 2'b11);
        chk("t2_awaddr", axi_awaddr, 32'h2000);
        chk("t2_awprot", axi_awprot, 3'b010);
        chk("t2_wdata", axi_wdata, 32'h12345678);
        chk("t2_wstrb", axi_wstrb, 4'hF);
        axi_awready = 1;
        #1 chk("t2_bready0", axi_bready, 0);
        @(negedge clk);
        axi_awready = 0; axi_wready = 1;
        chk("t2_aw_first", {axi_awvalid, axi_wvalid}, 2'b01);
        #1 chk("t2_bready1", axi_bready, 0);
        @(negedge clk);
        axi_wready = 0; axi_bvalid = 1; axi_bresp = 2;
        #1 chk("t2_w_done", {axi_awvalid, axi_wvalid}, 2'b00);
        chk("t2_bvalid", d_bvalid, 1);
        chk("t2_bresp", d_bresp, 2);
        chk("t2_bready", axi_bready, 1);
        @(negedge clk);
        axi_bvalid = 0;
        #1 chk("t2_idle_bvalid", d_bvalid, 0);

        // half a write request must not block fetch
        @(negedge clk);
        d_awvalid = 1; d_wvalid = 0; i_arvalid = 1; i_araddr = 32'h500;
        #1 chk("t4_i_arready", i_arready, 1);
        chk("t4_d_awready", d_awready, 0);
        @(negedge clk);
        i_arvalid = 0; axi_arready = 1;
        chk("t4_araddr", axi_araddr, 32'h500);
        @(negedge clk);
        axi_arready = 0; axi_rvalid = 1; axi_rresp = 2'b11;
        #1 chk("t4_rresp", i_rresp, 2'b11);
        @(negedge clk);
        axi_rvalid = 0;
        #1 chk("t4_awready_wait", {d_awready, d_wready, d_arready}, 0);
        @(negedge clk);
        d_wvalid = 1; d_awaddr = 32'h600; d_wdata = 32'hA5A5; d_wstrb = 4'h3;
        #1 chk("t4_awready_go", {d_awready, d_wready}, 2'b11);
        @(negedge clk);
        d_awvalid = 0; d_wvalid = 0; axi_awready = 1; axi_wready = 1;
        chk("t4_awaddr", axi_awaddr, 32'h600);
        chk("t4_wstrb", axi_wstrb, 4'h3);
        @(negedge clk);
        axi_awready = 0; axi_wready = 0; axi_bvalid = 1; axi_bresp = 0;
        #1 chk("t4_bvalid", d_bvalid, 1);
        chk("t4_both_clr", {axi_awvalid, axi_wvalid}, 0);
        @(negedge clk);
        axi_bvalid = 0;

        // asynchronous reset while waiting for read data
        @(negedge clk);
        i_arvalid = 1; i_araddr = 32'h700;
        @(negedge clk);
        i_arvalid = 0; axi_arready = 1;
        @(negedge clk);
        axi_arready = 0;
        #1 chk("t5_rready_pre", axi_rready, 1);
        chk("t5_araddr_pre", axi_araddr, 32'h700);
        #1 rst = 1;
        #1 chk("t5_rready_rst", axi_rready, 0);
        chk("t5_araddr_rst", axi_araddr, 0);
        chk("t5_arvalid_rst", axi_arvalid, 0);
        @(negedge clk);
        rst = 0; axi_rvalid = 1;
        #1 chk("t5_late_rvalid", {i_rvalid, d_rvalid}, 0);
        chk("t5_late_rready", axi_rready, 0);
        @(negedge clk);
        chk("t5_late_rready2", axi_rready, 0);
        chk("t5_late_rvalid2", {i_rvalid, d_rvalid}, 0);
        axi_rvalid = 0;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
